// File: rtl/tick_period_meter_if.sv
// Handshake and result bundle for tick_period_meter.
// master drives tick/start and reads results; slave is the meter itself.
interface tick_period_meter_if #(
    parameter int W = 29
);
    logic         tick;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] period;
    logic [1:0]   freq_code;
    logic         match;
    logic         timeout;

    modport master (
        output tick, start,
        input  busy, done, period, freq_code, match, timeout
    );

    modport slave (
        input  tick, start,
        output busy, done, period, freq_code, match, timeout
    );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the spacing, in clock cycles, between two consecutive tick-high samples
// and classifies it against three nominal periods.
module tick_period_meter #(
    parameter int W   = 29,
    parameter int P1  = 50000000,
    parameter int P2  = 100000000,
    parameter int P3  = 500000000,
    parameter int TOL = 16
) (
    input  logic              clock,
    input  logic              reset,
    tick_period_meter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] MEAS  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [W:0] P1_E  = (W+1)'(P1);
    localparam logic [W:0] P2_E  = (W+1)'(P2);
    localparam logic [W:0] P3_E  = (W+1)'(P3);
    localparam logic [W:0] TOL_E = (W+1)'(TOL);

    logic [1:0]   state;
    logic [W-1:0] counter;
    logic         sat;
    logic [W:0]   cnt_e;
    logic [1:0]   code_next;
    logic         hit;

    // Differences are taken one bit wider than the counter so they never wrap.
    function automatic logic [W:0] absdiff(input logic [W:0] a, input logic [W:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign sat   = (counter == '1);
    assign cnt_e = {1'b0, counter};

    always_comb begin
        code_next = 2'b00;
        hit       = 1'b1;
        if (counter == W'(1))
            code_next = 2'b00;
        else if (absdiff(cnt_e, P1_E) <= TOL_E)
            code_next = 2'b01;
        else if (absdiff(cnt_e, P2_E) <= TOL_E)
            code_next = 2'b10;
        else if (absdiff(cnt_e, P3_E) <= TOL_E)
            code_next = 2'b11;
        else
            hit = 1'b0;
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            bus.period    <= '0;
            bus.freq_code <= 2'b00;
            bus.match     <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        counter <= '0;
                        state   <= WAIT1;
                    end
                end
                WAIT1, MEAS: begin
                    if (bus.tick) begin
                        if (state == WAIT1) begin
                            counter <= W'(1);
                            state   <= MEAS;
                        end else begin
                            bus.period    <= counter;
                            bus.freq_code <= code_next;
                            bus.match     <= hit;
                            bus.timeout   <= 1'b0;
                            state         <= DONE;
                        end
                    end else if (sat) begin
                        // Saturated with no second tick: publish an aborted result.
                        bus.period    <= '1;
                        bus.freq_code <= 2'b00;
                        bus.match     <= 1'b0;
                        bus.timeout   <= 1'b1;
                        state         <= DONE;
                    end else begin
                        counter <= counter + W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter with W=8, P1=5, P2=10, P3=50, TOL=1.
module tb_tick_period_meter;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    tick_period_meter_if #(.W(W)) bus ();

    tick_period_meter #(
        .W  (W),
        .P1 (5),
        .P2 (10),
        .P3 (50),
        .TOL(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pulse start, then drive tick high on cycle 0 and every n cycles after (n=0: never).
    task automatic measure(input int n, input int restart_at, output int cycles, output bit got);
        bus.tick  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 1);
        got    = 1'b0;
        cycles = 0;
        for (int k = 0; k < 400; k++) begin
            bus.tick = (n >= 1) && (k % n == 0);
            if (k == restart_at) bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            cycles = k + 1;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        bus.tick = 1'b0;
    endtask

    task automatic check_result(input string tag, input bit got, input int cycles,
                                input int exp_cycles, input int exp_period, input int exp_code,
                                input int exp_match, input int exp_timeout);
        check({tag, "_done_seen"}, 32'(got), 1);
        check({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
        check({tag, "_period"}, 32'(bus.period), 32'(exp_period));
        check({tag, "_freq_code"}, 32'(bus.freq_code), 32'(exp_code));
        check({tag, "_match"}, 32'(bus.match), 32'(exp_match));
        check({tag, "_timeout"}, 32'(bus.timeout), 32'(exp_timeout));
        check({tag, "_busy_in_done"}, 32'(bus.busy), 1);
        step();
        check({tag, "_done_one_cycle"}, 32'(bus.done), 0);
        check({tag, "_idle_after"}, 32'(bus.busy), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_period"}, 32'(bus.period), 0);
        check({tag, "_freq_code"}, 32'(bus.freq_code), 0);
        check({tag, "_match"}, 32'(bus.match), 0);
        check({tag, "_timeout"}, 32'(bus.timeout), 0);
    endtask

    initial begin
        int cycles;
        bit got;
        int done_cnt;
        int busy_cnt;

        reset     = 1'b1;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        #3;
        check_cleared("reset");
        step();
        step();
        reset = 1'b0;
        step();
        check_cleared("after_reset");

        measure(1, -1, cycles, got);
        check_result("held_high", got, cycles, 2, 1, 0, 1, 0);
        check("hold_period", 32'(bus.period), 1);

        measure(10, -1, cycles, got);
        check_result("every10", got, cycles, 11, 10, 2, 1, 0);

        measure(6, -1, cycles, got);
        check_result("every6", got, cycles, 7, 6, 1, 1, 0);

        measure(8, -1, cycles, got);
        check_result("every8", got, cycles, 9, 8, 0, 0, 0);

        measure(0, -1, cycles, got);
        check_result("timeout", got, cycles, 256, 255, 0, 0, 1);

        measure(10, 3, cycles, got);
        check_result("restart_ignored", got, cycles, 11, 10, 2, 1, 0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        check("restart_no_extra_done", 32'(done_cnt), 0);
        check("restart_no_requeue", 32'(busy_cnt), 0);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.tick = (k % 50 == 0);
            step();
        end
        bus.tick = 1'b0;
        check("midmeas_busy", 32'(bus.busy), 1);
        check("midmeas_hold_period", 32'(bus.period), 10);
        check("midmeas_hold_code", 32'(bus.freq_code), 2);
        #2;
        reset = 1'b1;
        #1;
        check_cleared("async_reset");
        #2;
        reset = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 20; k < 80; k++) begin
            bus.tick = (k % 50 == 0);
            step();
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        bus.tick = 1'b0;
        check("reset_no_done", 32'(done_cnt), 0);
        check("reset_waits_start", 32'(busy_cnt), 0);

        measure(50, -1, cycles, got);
        check_result("every50", got, cycles, 51, 50, 3, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
